serial_pattern_gen: RTL and testbench

Moore-style serial bit-pattern transmitter. It accepts a parallel word through a load/ready handshake and shifts it out MSB-first, one bit per clock, on a single serial line. The word can optionally be repeated back-to-back. It is the stimulus and transmit end for the team's serial sequence-detector FSMs and is used as the bit-stream source in loop-back benches and demos.

---
 rtl/serial_pattern_gen.sv | 91 +++++++++
 tb/tb_serial_pattern_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial word transmitter with load/ready handshake and repeat count.
// Optional feature macro: SERIAL_PATTERN_GEN_PARITY_EN appends an even-parity bit after each word copy.
// Ports: clk; clr (sync active-low reset); data_in/reps captured when load && ready;
//        ready (idle), out (registered serial line), busy (transmitting), done (one-cycle end pulse).
module serial_pattern_gen #(
    parameter int   WIDTH    = 8,
    parameter int   REP_W    = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic [REP_W-1:0] reps,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd3;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    logic [1:0]       state;
    logic [WIDTH-1:0] word;
    logic [IW-1:0]    idx;
    logic [REP_W-1:0] rep_cnt;
    assign ready = state == S_IDLE;
    assign done  = state == S_DONE;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    assign busy  = (state == S_SHIFT) || (state == S_PARITY) || (state == S_DONE);
`else
    assign busy  = (state == S_SHIFT) || (state == S_DONE);
`endif
    // out is registered: each transition loads the bit the next state presents
    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= S_IDLE;
            word    <= '0;
            idx     <= '0;
            rep_cnt <= '0;
            out     <= IDLE_LVL;
        end else begin
            case (state)
                S_IDLE: if (load) begin
                    word    <= data_in;
                    rep_cnt <= reps;
                    idx     <= LAST;
                    out     <= data_in[WIDTH-1];
                    state   <= S_SHIFT;
                end
                S_SHIFT: if (idx != '0) begin
                    idx <= idx - IW'(1);
                    out <= word[idx - IW'(1)];
                end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                else begin
                    out   <= ^word;
                    state <= S_PARITY;
                end
                S_PARITY: begin
`else
                else begin
`endif
                    // end of a word copy: repeat without a gap bit, or finish
                    if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - REP_W'(1);
                        idx     <= LAST;
                        out     <= word[WIDTH-1];
                        state   <= S_SHIFT;
                    end else begin
                        out   <= IDLE_LVL;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    out   <= IDLE_LVL;
                    state <= S_IDLE;
                end
                default: begin
                    out   <= IDLE_LVL;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: randomized and directed checks of serial_pattern_gen against a bit-queue model.
module tb_serial_pattern_gen;
    localparam int WIDTH = 8;
    localparam int REP_W = 4;
    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [REP_W-1:0] reps = '0;
    logic             load = 1'b0;
    logic             ready, out, busy, done;
    int               chk = 0;
    int               err = 0;
    bit               q[$];
    serial_pattern_gen #(.WIDTH(WIDTH), .REP_W(REP_W), .IDLE_LVL(1'b0)) dut (
        .clk(clk), .clr(clr), .data_in(data_in), .reps(reps), .load(load),
        .ready(ready), .out(out), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk++;
        assert (got === exp) else begin
            err++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_out"}, 32'(out), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask
    // expected serial stream: word MSB-first, optional even parity, repeated reps+1 times
    task automatic build(input logic [WIDTH-1:0] w, input int r);
        q.delete();
        for (int k = 0; k <= r; k++) begin
            for (int b = WIDTH - 1; b >= 0; b--) q.push_back(w[b]);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            q.push_back(^w);
`endif
        end
    endtask
    // send one word; noisy drives load with random data during the stream
    task automatic send(input string tag, input logic [WIDTH-1:0] w, input int r, input bit noisy);
        int n;
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        build(w, r);
        n = q.size();
        data_in = w;
        reps = REP_W'(r);
        load = 1'b1;
        tick();
        load = noisy;
        for (int i = 0; i < n; i++) begin
            if (noisy) begin
                data_in = WIDTH'($urandom);
                reps = REP_W'($urandom);
            end
            check($sformatf("%s_bit%0d", tag, i), 32'(out), 32'(q[i]));
            check($sformatf("%s_busy%0d", tag, i), {29'd0, busy, ready, done}, 32'b100);
            tick();
        end
        load = 1'b0;
        check({tag, "_done"}, {29'd0, done, busy, ready}, 32'b110);
        check({tag, "_done_out"}, 32'(out), 32'd0);
        tick();
        check_idle({tag, "_after"});
    endtask
    initial begin
        // reset held with load asserted: nothing accepted
        load = 1'b1;
        data_in = 8'hA5;
        reps = 4'd3;
        tick();
        check_idle("rst0");
        tick();
        check_idle("rst1");
        load = 1'b0;
        clr = 1'b1;
        tick();
        check_idle("rst_rel");
        send("a5", 8'hA5, 0, 1'b0);
        send("3c_r2", 8'h3C, 2, 1'b0);
        send("a5_noise", 8'hA5, 0, 1'b1);
        send("ff_r15", 8'hFF, 15, 1'b0);
        send("01", 8'h01, 0, 1'b0);
        send("07_r1", 8'h07, 1, 1'b1);
        // abort mid-stream while word bit 4 is on out
        build(8'hA5, 0);
        data_in = 8'hA5;
        reps = '0;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_bit%0d", i), 32'(out), 32'(q[i]));
            if (i < 3) tick();
        end
        clr = 1'b0;
        tick();
        clr = 1'b1;
        check_idle("abort");
        tick();
        check_idle("abort_nodone");
        send("post_abort", 8'h5A, 1, 1'b0);
        for (int t = 0; t < 10; t++)
            send($sformatf("rnd%0d", t), WIDTH'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
